// File: rtl/rv_skid_buffer.sv
// Two-entry ready/valid register slice: output register plus one skid register, all handshakes registered.
// Optional RV_SKID_BUFFER_STALL_CNT_EN adds a saturating 16-bit stall_cnt output.
module rv_skid_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int DATA2_WIDTH = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic signed [DATA2_WIDTH-1:0] in_data2,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic signed [DATA2_WIDTH-1:0] out_data2,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef RV_SKID_BUFFER_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                          state, state_d;
    logic [DATA_WIDTH-1:0]           skid_data;
    logic signed [DATA2_WIDTH-1:0]   skid_data2;
    logic                            in_xfer, out_xfer;
    logic                            load_out_in, load_out_skid, load_skid;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_comb begin
        state_d       = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: if (in_xfer) begin
                state_d     = ONE;
                load_out_in = 1'b1;
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (in_xfer && out_xfer) begin
                    load_out_in = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (out_xfer) begin
                state_d       = ONE;
                load_out_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state so neither depends combinationally on the peer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_data2  <= '0;
            skid_data  <= '0;
            skid_data2 <= '0;
        end else begin
            state     <= state_d;
            in_ready  <= (state_d != FULL);
            out_valid <= (state_d != EMPTY);
            if (load_out_in) begin
                out_data  <= in_data;
                out_data2 <= in_data2;
            end else if (load_out_skid) begin
                out_data  <= skid_data;
                out_data2 <= skid_data2;
            end
            if (load_skid) begin
                skid_data  <= in_data;
                skid_data2 <= in_data2;
            end
        end
    end

`ifdef RV_SKID_BUFFER_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_rv_skid_buffer.sv
// Scoreboard bench for rv_skid_buffer: the model is a queue of accepted beats; occupancy drives ready/valid expectations.
module tb_rv_skid_buffer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [15:0]        in_data = '0;
    logic signed [12:0] in_data2 = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [15:0]        out_data;
    logic signed [12:0] out_data2;
    logic               out_valid;
    logic               out_ready = 1'b0;
`ifdef RV_SKID_BUFFER_STALL_CNT_EN
    logic [15:0]        stall_cnt;
    logic [15:0]        stall_exp = '0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [28:0] q[$];
    logic        rst_seen = 1'b1;
    logic        prev_stall = 1'b0;
    logic [28:0] prev_out = '0;
    int          n_out = 0;

    rv_skid_buffer dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_data2(in_data2), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_data2(out_data2), .out_valid(out_valid), .out_ready(out_ready)
`ifdef RV_SKID_BUFFER_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: samples 3 time units after negedge, before the stimulus commits this cycle's pushes.
    always @(negedge clk) begin
        #3;
        chk("in_ready", {31'd0, in_ready}, {31'd0, !rst_seen && q.size() < 2});
        chk("out_valid", {31'd0, out_valid}, {31'd0, !rst_seen && q.size() > 0});
        if (rst_seen) begin
            chk("rst_data", {16'd0, out_data}, 32'd0);
            chk("rst_data2", {19'd0, out_data2}, 32'd0);
        end
        if (out_valid && q.size() > 0)
            chk("payload", {3'd0, out_data, out_data2}, {3'd0, q[0]});
        if (prev_stall && !rst_seen)
            chk("stall_hold", {3'd0, out_valid ? {out_data, out_data2} : 29'h1FFFFFFF}, {3'd0, prev_out});
        prev_stall = out_valid && !out_ready && !rst;
        prev_out   = {out_data, out_data2};
        if (out_valid && out_ready && !rst && q.size() > 0) begin
            void'(q.pop_front());
            n_out++;
        end
`ifdef RV_SKID_BUFFER_STALL_CNT_EN
        chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, stall_exp});
        if (rst) stall_exp = '0;
        else if (out_valid && !out_ready && stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
`endif
    end

    task automatic cyc(input logic r, input logic iv, input logic [15:0] d, input logic [12:0] d2,
                       input logic ordy, output logic acc);
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; in_data2 = d2; out_ready = ordy;
        #4;
        acc = iv && in_ready && !r;
        if (acc) q.push_back({d, d2});
        if (r) q.delete();
        rst_seen = r;
    endtask

    logic        acc;
    logic        pend;
    logic [15:0] rd;
    logic [12:0] rd2;
    int          n;

    initial begin
        // reset then idle
        repeat (3) cyc(1, 0, 16'h0, 13'h0, 0, acc);
        repeat (3) cyc(0, 0, 16'h0, 13'h0, 1, acc);

        // single beat, data2 = -1
        cyc(0, 1, 16'hBEEF, 13'h1FFF, 1, acc);
        chk("single_acc", {31'd0, acc}, 32'd1);
        cyc(0, 0, 16'h0, 13'h0, 1, acc);
        repeat (2) cyc(0, 0, 16'h0, 13'h0, 1, acc);

        // backpressure fill
        cyc(0, 1, 16'd1, 13'd1, 0, acc); chk("fill_acc_a", {31'd0, acc}, 32'd1);
        cyc(0, 1, 16'd2, 13'd2, 0, acc); chk("fill_acc_b", {31'd0, acc}, 32'd1);
        cyc(0, 1, 16'd3, 13'd3, 0, acc); chk("fill_hold_c", {31'd0, acc}, 32'd0);
        cyc(0, 1, 16'd3, 13'd3, 0, acc); chk("fill_hold_c2", {31'd0, acc}, 32'd0);
        cyc(0, 1, 16'd3, 13'd3, 1, acc); chk("fill_c_blocked_at_drain", {31'd0, acc}, 32'd0);
        cyc(0, 1, 16'd3, 13'd3, 1, acc); chk("fill_acc_c", {31'd0, acc}, 32'd1);
        repeat (4) cyc(0, 0, 16'h0, 13'h0, 1, acc);
        chk("fill_drained", q.size(), 0);

        // streaming 0..99
        n_out = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(0, 1, i[15:0], i[12:0], 1, acc);
            chk("stream_acc", {31'd0, acc}, 32'd1);
        end
        cyc(0, 0, 16'h0, 13'h0, 1, acc);
        chk("stream_count", n_out, 100);
        repeat (2) cyc(0, 0, 16'h0, 13'h0, 1, acc);

        // random valid/ready, upstream holds an offered beat until accepted
        n = 0; pend = 1'b0; rd = '0; rd2 = '0;
        while (n < 1000) begin
            if (!pend) begin
                pend = ($urandom % 2) == 1;
                rd   = 16'($urandom);
                rd2  = 13'($urandom_range(0, 8191));
            end
            cyc(0, pend, rd, rd2, ($urandom % 2) == 1, acc);
            if (acc) begin n++; pend = 1'b0; end
        end
        repeat (5) cyc(0, 0, 16'h0, 13'h0, 1, acc);
        chk("random_drained", q.size(), 0);

        // mid-stream reset from FULL
        cyc(0, 1, 16'hAAAA, 13'h0AA, 0, acc);
        cyc(0, 1, 16'h5555, 13'h155, 0, acc);
        cyc(0, 0, 16'h0, 13'h0, 0, acc);
        chk("midrst_full", q.size(), 2);
        cyc(1, 0, 16'h0, 13'h0, 0, acc);
        n_out = 0;
        repeat (10) cyc(0, 0, 16'h0, 13'h0, 1, acc);
        chk("midrst_no_beats", n_out, 0);

`ifdef RV_SKID_BUFFER_STALL_CNT_EN
        cyc(0, 1, 16'h1234, 13'h0034, 0, acc);
        repeat (70000) cyc(0, 0, 16'h0, 13'h0, 0, acc);
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        repeat (3) cyc(0, 0, 16'h0, 13'h0, 1, acc);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
